// File: rtl/mdio_pkg.sv
// Shared constants, register map and FSM state type for the Clause-22 MDIO responder.
package mdio_pkg;

    localparam logic [1:0] OP_RD = 2'b10;
    localparam logic [1:0] OP_WR = 2'b01;

    localparam logic [4:0] REG_BMCR  = 5'd0;
    localparam logic [4:0] REG_BMSR  = 5'd1;
    localparam logic [4:0] REG_ID1   = 5'd2;
    localparam logic [4:0] REG_ID2   = 5'd3;
    localparam logic [4:0] REG_ANAR  = 5'd4;
    localparam logic [4:0] REG_GBCR  = 5'd9;
    localparam logic [4:0] REG_PHYSR = 5'd17;

    localparam logic [15:0] BMCR_RST = 16'h1140;
    localparam logic [15:0] ANAR_RST = 16'h01E1;
    localparam logic [15:0] GBCR_RST = 16'h0300;

    // Fixed upper bits of BMSR: 100BASE-TX FD/HD and 10BASE-T FD/HD capable.
    localparam logic [8:0] BMSR_HI = 9'b011110000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_OP,
        ST_PHYAD,
        ST_REGAD,
        ST_TA,
        ST_DATA
    } mdio_state_e;

    function automatic logic [15:0] reg_reset_val(input logic [4:0] addr);
        logic [15:0] val;
        val = 16'h0000;
        case (addr)
            REG_BMCR: val = BMCR_RST;
            REG_ANAR: val = ANAR_RST;
            REG_GBCR: val = GBCR_RST;
            default:  val = 16'h0000;
        endcase
        return val;
    endfunction

    function automatic logic reg_is_ro(input logic [4:0] addr);
        return (addr == REG_BMSR) || (addr == REG_ID1) ||
               (addr == REG_ID2)  || (addr == REG_PHYSR);
    endfunction

endpackage

// File: rtl/mdio_phy_responder_if.sv
// MDIO management bus: MDC and the split MDIO pad (input, output value, output enable).
interface mdio_phy_responder_if;
    logic mdc;
    logic mdio_i;
    logic mdio_o;
    logic mdio_oe;

    modport master (
        output mdc,
        output mdio_i,
        input  mdio_o,
        input  mdio_oe
    );

    modport slave (
        input  mdc,
        input  mdio_i,
        output mdio_o,
        output mdio_oe
    );
endinterface

// File: rtl/mdio_sync_edge.sv
// Brings MDC and MDIO into the clk domain and produces single-cycle MDC rise/fall strobes.
module mdio_sync_edge (
    input  logic clk,
    input  logic rstn,
    input  logic mdc,
    input  logic mdio_i,
    output logic mdc_rise,
    output logic mdc_fall,
    output logic mdio_s
);
    logic [2:0] mdc_q;
    logic [1:0] mdio_q;

    // Reset to the idle-high level so releasing reset with MDC high makes no false rise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mdc_q  <= 3'b111;
            mdio_q <= 2'b11;
        end else begin
            mdc_q  <= {mdc_q[1:0], mdc};
            mdio_q <= {mdio_q[0], mdio_i};
        end
    end

    assign mdc_rise = mdc_q[1] & ~mdc_q[2];
    assign mdc_fall = ~mdc_q[1] & mdc_q[2];
    assign mdio_s   = mdio_q[1];

endmodule

// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO slave with a 32x16 register file, link/speed status and BMCR soft reset.
// Define MDIO_PREAMBLE_SUPPRESS_EN to accept frames after a single preamble 1 (BMSR bit6 = 1).
module mdio_phy_responder
    import mdio_pkg::*;
#(
    parameter logic [4:0]  PHY_ADDR    = 5'd1,
    parameter logic [15:0] PHY_ID1     = 16'h001C,
    parameter logic [15:0] PHY_ID2     = 16'hC915,
    parameter int          TIMEOUT_CYC = 1024
) (
    input  logic                clk,
    input  logic                rstn,
    mdio_phy_responder_if.slave mdio,
    input  logic                link_i,
    input  logic [1:0]          speed_i,
    output logic                wr_valid,
    output logic [4:0]          wr_addr,
    output logic [15:0]         wr_data,
    output logic                soft_rst,
    output mdio_state_e         state_dbg
);

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    localparam logic [5:0] PRE_NEED = 6'd1;
    localparam logic       PRE_SUP  = 1'b1;
`else
    localparam logic [5:0] PRE_NEED = 6'd32;
    localparam logic       PRE_SUP  = 1'b0;
`endif
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic        mdc_rise;
    logic        mdc_fall;
    logic        mdio_bit;

    mdio_state_e state, state_nxt;
    logic [4:0]  cnt, cnt_nxt;
    logic [5:0]  pre_cnt, pre_nxt;
    logic [1:0]  op, op_nxt;
    logic [4:0]  phyad, phyad_nxt;
    logic [4:0]  regad, regad_nxt;
    logic [15:0] wsh, wsh_nxt;
    logic        latch_rd;
    logic        commit;
    logic        timeout;

    logic [TO_W-1:0] to_cnt;
    logic [15:0]     regs [32];
    logic [15:0]     tx;
    logic            mine;
    logic [15:0]     rd_val;
    logic [15:0]     bmsr;
    logic            rd_mine;
    logic [3:0]      tx_idx;

    mdio_sync_edge u_sync (
        .clk      (clk),
        .rstn     (rstn),
        .mdc      (mdio.mdc),
        .mdio_i   (mdio.mdio_i),
        .mdc_rise (mdc_rise),
        .mdc_fall (mdc_fall),
        .mdio_s   (mdio_bit)
    );

    assign state_dbg = state;
    assign rd_mine   = mine && (op == OP_RD);
    assign tx_idx    = 4'd15 - cnt[3:0];
    assign bmsr      = {BMSR_HI, PRE_SUP, 3'b000, link_i, 2'b01};

    // A frame stalled with MDC parked for TIMEOUT_CYC clocks is abandoned.
    assign timeout = (state != ST_IDLE) && !mdc_rise &&
                     (to_cnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            to_cnt <= '0;
        end else if (mdc_rise || state == ST_IDLE || timeout) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            pre_cnt <= '0;
            op      <= '0;
            phyad   <= '0;
            regad   <= '0;
            wsh     <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pre_cnt <= pre_nxt;
            op      <= op_nxt;
            phyad   <= phyad_nxt;
            regad   <= regad_nxt;
            wsh     <= wsh_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pre_nxt   = pre_cnt;
        op_nxt    = op;
        phyad_nxt = phyad;
        regad_nxt = regad;
        wsh_nxt   = wsh;
        latch_rd  = 1'b0;
        commit    = 1'b0;
        if (timeout) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            pre_nxt   = '0;
        end else if (mdc_rise) begin
            unique case (state)
                ST_IDLE: begin
                    if (!mdio_bit) begin
                        pre_nxt = '0;
                    end else begin
                        pre_nxt = (pre_cnt == 6'd32) ? pre_cnt : pre_cnt + 6'd1;
                        if (pre_nxt == PRE_NEED) begin
                            state_nxt = ST_START;
                            cnt_nxt   = '0;
                            pre_nxt   = '0;
                        end
                    end
                end
                // cnt[0] remembers that the ST '0' has been seen.
                ST_START: begin
                    if (!cnt[0]) begin
                        if (!mdio_bit) cnt_nxt = 5'd1;
                    end else if (mdio_bit) begin
                        state_nxt = ST_OP;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end
                end
                ST_OP: begin
                    op_nxt = {op[0], mdio_bit};
                    if (cnt == 5'd1) begin
                        cnt_nxt   = '0;
                        state_nxt = (op_nxt == OP_RD || op_nxt == OP_WR) ? ST_PHYAD : ST_IDLE;
                    end else begin
                        cnt_nxt = cnt + 5'd1;
                    end
                end
                ST_PHYAD: begin
                    phyad_nxt = {phyad[3:0], mdio_bit};
                    if (cnt == 5'd4) begin
                        state_nxt = ST_REGAD;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 5'd1;
                    end
                end
                ST_REGAD: begin
                    regad_nxt = {regad[3:0], mdio_bit};
                    if (cnt == 5'd4) begin
                        state_nxt = ST_TA;
                        cnt_nxt   = '0;
                        latch_rd  = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 5'd1;
                    end
                end
                // A write turnaround must read back as 1 then 0.
                ST_TA: begin
                    if (cnt == 5'd0) begin
                        if (op == OP_WR && !mdio_bit) begin
                            state_nxt = ST_IDLE;
                        end else begin
                            cnt_nxt = 5'd1;
                        end
                    end else if (op == OP_WR && mdio_bit) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = ST_DATA;
                        cnt_nxt   = '0;
                    end
                end
                ST_DATA: begin
                    wsh_nxt = {wsh[14:0], mdio_bit};
                    if (cnt == 5'd15) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                        commit    = (op == OP_WR);
                    end else begin
                        cnt_nxt = cnt + 5'd1;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Read data is captured the moment REGAD completes, so live inputs are sampled once.
    always_comb begin
        rd_val = regs[regad_nxt];
        case (regad_nxt)
            REG_BMSR:  rd_val = bmsr;
            REG_ID1:   rd_val = PHY_ID1;
            REG_ID2:   rd_val = PHY_ID2;
            REG_PHYSR: rd_val = {speed_i, 1'b1, 13'b0};
            default:   rd_val = regs[regad_nxt];
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx   <= '0;
            mine <= 1'b0;
        end else if (latch_rd) begin
            tx   <= rd_val;
            mine <= (phyad == PHY_ADDR);
        end
    end

    // wr_valid is a single-cycle notification with no backpressure; wr_addr/wr_data
    // are valid in that cycle and hold their value until the next accepted write.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 32; i++) regs[i] <= reg_reset_val(5'(i));
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            soft_rst <= 1'b0;
        end else begin
            wr_valid <= 1'b0;
            soft_rst <= 1'b0;
            if (commit && mine && !reg_is_ro(regad)) begin
                wr_valid <= 1'b1;
                wr_addr  <= regad;
                wr_data  <= wsh_nxt;
                if (regad == REG_BMCR && wsh_nxt[15]) begin
                    regs[regad] <= BMCR_RST;
                    soft_rst    <= 1'b1;
                end else begin
                    regs[regad] <= wsh_nxt;
                end
            end
        end
    end

    // Pad drive changes only on MDC fall strobes; any non-driving slot releases the bus.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mdio.mdio_o  <= 1'b1;
            mdio.mdio_oe <= 1'b0;
        end else if (timeout) begin
            mdio.mdio_o  <= 1'b1;
            mdio.mdio_oe <= 1'b0;
        end else if (mdc_fall) begin
            if (state == ST_TA && cnt == 5'd1 && rd_mine) begin
                mdio.mdio_oe <= 1'b1;
                mdio.mdio_o  <= 1'b0;
            end else if (state == ST_DATA && rd_mine) begin
                mdio.mdio_oe <= 1'b1;
                mdio.mdio_o  <= tx[tx_idx];
            end else begin
                mdio.mdio_oe <= 1'b0;
                mdio.mdio_o  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Bench for mdio_phy_responder: an MDIO master drives frames bit by bit, a register-map
// model predicts read data, pad drive per bit slot and the write/soft-reset events.
module tb_mdio_phy_responder;
    import mdio_pkg::*;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    localparam bit SUP = 1'b1;
`else
    localparam bit SUP = 1'b0;
`endif

    logic        clk;
    logic        rstn;
    logic        link_i;
    logic [1:0]  speed_i;
    logic        wr_valid;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic        soft_rst;
    mdio_state_e state_dbg;

    logic m_en;
    logic m_val;
    logic slot_live;
    logic slot_e_oe;
    logic slot_e_o;

    int checks   = 0;
    int failures = 0;

    logic [21:0] exp_q[$];
    logic [15:0] m_regs [32];

    mdio_phy_responder_if bus ();

    // Open-drain style bus with pull-up: responder wins when enabled, else master, else 1.
    assign bus.mdio_i = bus.mdio_oe ? bus.mdio_o : (m_en ? m_val : 1'b1);

    mdio_phy_responder #(
        .PHY_ADDR    (5'd1),
        .PHY_ID1     (16'h001C),
        .PHY_ID2     (16'hC915),
        .TIMEOUT_CYC (1024)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .mdio      (bus.slave),
        .link_i    (link_i),
        .speed_i   (speed_i),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .soft_rst  (soft_rst),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural register-map model ----------------
    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 16'h0000;
        m_regs[0] = 16'h1140;
        m_regs[4] = 16'h01E1;
        m_regs[9] = 16'h0300;
    endtask

    function automatic logic [15:0] model_read(input logic [4:0] a);
        if (a == 5'd1)  return 16'h7801 + (link_i ? 16'h0004 : 16'h0000) + (SUP ? 16'h0040 : 16'h0000);
        if (a == 5'd2)  return 16'h001C;
        if (a == 5'd3)  return 16'hC915;
        if (a == 5'd17) return {speed_i, 14'h2000};
        return m_regs[a];
    endfunction

    function automatic logic heard(input int n_pre, input logic [4:0] pa);
        return (pa == 5'd1) && (n_pre >= 32 || SUP);
    endfunction

    // ---------------- scoreboard: write / soft-reset events ----------------
    always @(negedge clk) begin
        if (rstn && (wr_valid || soft_rst)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wr_unexpected act=%h exp=none", {soft_rst, wr_addr, wr_data});
            end else begin
                chk("wr_event", {10'd0, soft_rst, wr_addr, wr_data}, {10'd0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- compare process: pad drive at every master sampling edge ----------------
    always @(posedge bus.mdc) begin
        if (slot_live) begin
            chk("slot_oe", {31'd0, bus.mdio_oe}, {31'd0, slot_e_oe});
            if (slot_e_oe) chk("slot_o", {31'd0, bus.mdio_o}, {31'd0, slot_e_o});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic slot(input logic en, input logic val, input logic e_oe, input logic e_o,
                        output logic s);
        @(negedge clk);
        bus.mdc   = 1'b0;
        m_en      = en;
        m_val     = val;
        slot_e_oe = e_oe;
        slot_e_o  = e_o;
        slot_live = 1'b1;
        repeat (5) @(negedge clk);
        bus.mdc = 1'b1;
        @(negedge clk);
        s = bus.mdio_i;
        repeat (3) @(negedge clk);
    endtask

    task automatic frame_head(input int n_pre, input logic [1:0] op, input logic [4:0] pa,
                              input logic [4:0] ra);
        logic s;
        logic [13:0] hdr;
        hdr = {2'b01, op, pa, ra};
        for (int i = 0; i < n_pre; i++) slot(1'b1, 1'b1, 1'b0, 1'b1, s);
        for (int i = 13; i >= 0; i--) slot(1'b1, hdr[i], 1'b0, 1'b1, s);
    endtask

    task automatic read_body(input logic answered, input logic [15:0] exp, input int n_data,
                             output logic [15:0] rd);
        logic s;
        rd = 16'hFFFF;
        slot(1'b0, 1'b1, 1'b0, 1'b1, s);
        slot(1'b0, 1'b1, answered, 1'b0, s);
        for (int i = 0; i < n_data; i++) begin
            slot(1'b0, 1'b1, answered, exp[15-i], s);
            rd[15-i] = s;
        end
    endtask

    task automatic frame_read(input int n_pre, input logic [4:0] pa, input logic [4:0] ra,
                              output logic [15:0] rd, output logic [15:0] exp);
        logic ans;
        ans = heard(n_pre, pa);
        exp = ans ? model_read(ra) : 16'hFFFF;
        frame_head(n_pre, OP_RD, pa, ra);
        read_body(ans, exp, 16, rd);
    endtask

    task automatic frame_write(input logic [4:0] pa, input logic [4:0] ra, input logic [15:0] wd);
        logic s;
        if (pa == 5'd1 && !(ra == 5'd1 || ra == 5'd2 || ra == 5'd3 || ra == 5'd17)) begin
            exp_q.push_back({(ra == 5'd0) && wd[15], ra, wd});
            m_regs[ra] = ((ra == 5'd0) && wd[15]) ? 16'h1140 : wd;
        end
        frame_head(32, OP_WR, pa, ra);
        slot(1'b1, 1'b1, 1'b0, 1'b1, s);
        slot(1'b1, 1'b0, 1'b0, 1'b1, s);
        for (int i = 15; i >= 0; i--) slot(1'b1, wd[i], 1'b0, 1'b1, s);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] rd;
        logic [15:0] ex;
        logic        s;
        logic [4:0]  pa;
        logic [4:0]  ra;
        logic [15:0] wd;

        rstn      = 1'b0;
        bus.mdc   = 1'b1;
        m_en      = 1'b0;
        m_val     = 1'b1;
        slot_live = 1'b0;
        slot_e_oe = 1'b0;
        slot_e_o  = 1'b1;
        link_i    = 1'b0;
        speed_i   = 2'b00;
        model_reset();
        repeat (5) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_mdio_o",   {31'd0, bus.mdio_o},  32'd1);
        chk("rst_mdio_oe",  {31'd0, bus.mdio_oe}, 32'd0);
        chk("rst_wr_valid", {31'd0, wr_valid},    32'd0);
        chk("rst_wr_addr",  {27'd0, wr_addr},     32'd0);
        chk("rst_wr_data",  {16'd0, wr_data},     32'd0);
        chk("rst_soft_rst", {31'd0, soft_rst},    32'd0);
        chk("rst_state",    {29'd0, state_dbg},   {29'd0, ST_IDLE});

        // PHY identifier
        frame_read(32, 5'd1, 5'd2, rd, ex);
        chk("rd_id1", {16'd0, rd}, 32'h001C);
        chk("rd_id1_model", {16'd0, ex}, 32'h001C);

        // write then read back ANAR
        frame_write(5'd1, 5'd4, 16'h05E1);
        frame_read(32, 5'd1, 5'd4, rd, ex);
        chk("rd_anar", {16'd0, rd}, 32'h05E1);

        // link status reflected live in BMSR
        link_i = 1'b1;
        frame_read(32, 5'd1, 5'd1, rd, ex);
        chk("rd_bmsr_up", {16'd0, rd}, SUP ? 32'h7845 : 32'h7805);
        link_i = 1'b0;
        frame_read(32, 5'd1, 5'd1, rd, ex);
        chk("rd_bmsr_dn", {16'd0, rd}, SUP ? 32'h7841 : 32'h7801);

        // speed in PHYSR
        speed_i = 2'b10;
        frame_read(32, 5'd1, 5'd17, rd, ex);
        chk("rd_physr", {16'd0, rd}, 32'hA000);
        chk("rd_physr_model", {16'd0, ex}, 32'hA000);

        // foreign PHYAD and read-only register writes are dropped
        frame_write(5'd3, 5'd4, 16'h1234);
        frame_write(5'd1, 5'd1, 16'hFFFF);
        frame_read(32, 5'd1, 5'd4, rd, ex);
        chk("rd_anar_kept", {16'd0, rd}, 32'h05E1);
        frame_read(32, 5'd3, 5'd4, rd, ex);
        chk("rd_foreign", {16'd0, rd}, 32'hFFFF);

        // BMCR soft reset
        frame_write(5'd1, 5'd0, 16'h9140);
        frame_read(32, 5'd1, 5'd0, rd, ex);
        chk("rd_bmcr_after_srst", {16'd0, rd}, 32'h1140);

        // MDC parks after REGAD: frame must be abandoned
        frame_head(32, OP_RD, 5'd1, 5'd2);
        repeat (1100) @(negedge clk);
        chk("to_state", {29'd0, state_dbg}, {29'd0, ST_IDLE});
        chk("to_oe", {31'd0, bus.mdio_oe}, 32'd0);
        frame_read(32, 5'd1, 5'd3, rd, ex);
        chk("rd_id2_after_to", {16'd0, rd}, 32'hC915);

        // back-to-back frame with only one preamble bit
        frame_read(1, 5'd1, 5'd2, rd, ex);
        chk("rd_short_pre", {16'd0, rd}, SUP ? 32'h001C : 32'hFFFF);

        // randomized traffic against the model
        for (int n = 0; n < 40; n++) begin
            link_i  = 1'($urandom_range(0, 1));
            speed_i = 2'($urandom_range(0, 2));
            pa      = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'd1;
            ra      = 5'($urandom_range(0, 31));
            wd      = 16'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                frame_write(pa, ra, wd);
            end else begin
                frame_read(32, pa, ra, rd, ex);
                chk("rand_rd", {16'd0, rd}, {16'd0, ex});
            end
        end

        // asynchronous reset in the middle of a read data phase
        frame_head(32, OP_RD, 5'd1, 5'd4);
        read_body(1'b1, model_read(5'd4), 6, rd);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("arst_oe", {31'd0, bus.mdio_oe}, 32'd0);
        chk("arst_state", {29'd0, state_dbg}, {29'd0, ST_IDLE});
        repeat (3) @(negedge clk);
        model_reset();
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        frame_read(32, 5'd1, 5'd4, rd, ex);
        chk("rd_anar_after_rst", {16'd0, rd}, 32'h01E1);

        // trailing idle slot confirms the bus was released after the last D0
        slot(1'b0, 1'b1, 1'b0, 1'b1, s);
        repeat (10) @(negedge clk);
        chk("exp_q_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdio_phy_responder.md
Name: mdio_phy_responder

Overview:
- Clause-22 MDIO/SMI slave: the PHY-side counterpart of the switch's SMI master (MDC/MDIO config engine).
- Sits on the management pins of a port model or on-chip PHY shim.
- Decodes read and write frames and serves a 32x16 register file; link and speed are reflected in the status registers.
- Allows the port's smi_config master to be closed-loop tested and the PHY register map to be emulated.

Parameters:
- PHY_ADDR, 5'd1, PHYAD this responder answers to.
- PHY_ID1, 16'h001C, value of reg 2 (read-only).
- PHY_ID2, 16'hC915, value of reg 3 (read-only).
- TIMEOUT_CYC, 1024, clk cycles without an MDC rising edge before an in-progress frame is aborted.

Ports:
- clk  in  1  system clock; MDC period must be >= 8 clk periods.
- rstn  in  1  asynchronous active-low reset.
- mdc  in  1  management clock from master (asynchronous to clk).
- mdio_i  in  1  MDIO pad input.
- mdio_o  out  1  MDIO pad output value.
- mdio_oe  out  1  MDIO output enable (1 = drive).
- link_i  in  1  link status.
- speed_i  in  2  00=10M, 01=100M, 10=1000M.
- wr_valid  out  1  one-clk pulse on an accepted register write.
- wr_addr  out  5  register address of the write.
- wr_data  out  16  data of the write.
- soft_rst  out  1  one-clk pulse when BMCR bit15 is written as 1.

Behaviour:
- Reset values: mdio_o=1, mdio_oe=0, wr_valid=0, wr_addr=0, wr_data=0, soft_rst=0, FSM=IDLE.
- Register resets: reg0=16'h1140, reg4=16'h01E1, reg9=16'h0300, all other writable regs=0.
- MDC and mdio_i pass through 2-flop synchronizers; a third mdc flop gives the rise/fall strobes.
- MDIO is sampled on the rise strobe. mdio_o/mdio_oe update on the fall strobe, which is 3 clk after the MDC pin falls.
- FSM states and transitions:
  - IDLE: count consecutive sampled 1s (saturating at 32). When count=32, go to START. A sampled 0 clears the count.
  - START: waits through the remaining 1s. A 0 followed by a 1 (ST=01) goes to OP. Two 0s go to IDLE.
  - OP: 2 bits. 10=read, 01=write, 00/11 go to IDLE.
  - PHYAD: 5 bits, MSB first, then REGAD: 5 bits. A frame is "mine" when PHYAD==PHY_ADDR.
  - TA, read and mine:
    - Bit 1: no drive.
    - Fall strobe after the bit-1 rise: mdio_oe=1, mdio_o=0.
  - TA, write: the two sampled bits must be 10, otherwise go to IDLE with no write.
  - TA, not mine: same 2-bit slot, never driven.
  - DATA: 16 bits.
    - Read: drive D15..D0 on successive fall strobes. The value is latched at REGAD completion.
    - Write: shift in on rises.
  - After DATA, go to IDLE. Read: mdio_oe=0 on the fall strobe after D0 was driven.
- Write commit: on the rise that samples D0 of a mine write, with the regfile updated in the same cycle.
  - wr_valid pulses only for a mine write to a writable address.
  - Writes to 1, 2, 3, 17 are ignored with no pulse.
- Read map:
  - reg1 = {9'b011110000, 4'b0, link_i, 2'b01}, read live at latch time.
  - reg2/3 = PHY_ID1/2.
  - reg17 = {speed_i, 1'b1 /*duplex*/, 13'b0}.
  - Others return stored values.
- BMCR soft reset: a write with bit15=1 restores reg0 to its default (bit15 reads 0) and pulses soft_rst. Other regs are untouched.
- Timeout: outside IDLE, TIMEOUT_CYC clk with no rise strobe forces IDLE, mdio_oe=0, preamble count=0.
- Back-to-back frames: after DATA, a new frame needs a fresh preamble. A 1-bit idle is enough only with the optional feature below.
- Async reset mid-read releases the bus immediately.

Optional Feature:
- MDIO_PREAMBLE_SUPPRESS_EN: when defined, IDLE goes to START after a single sampled 1 (preamble suppression, BMSR bit6 reads 1).
- When undefined, the full 32-bit preamble is required and BMSR bit6 reads 0.

Decomposition:
- Package mdio_pkg:
  - OP_RD=2'b10, OP_WR=2'b01.
  - Register address constants (BMCR=0, BMSR=1, ID1=2, ID2=3, ANAR=4, GBCR=9, PHYSR=17).
  - Reset constants.
  - FSM state enum.
- Sub-module mdio_sync_edge: 2-flop synchronizers for mdc/mdio_i plus rise/fall strobe generation.

Test Plan:
- Read reg2, PHYAD=1, 32-bit preamble -> data shifted out = 16'h001C. TA bit2=0, bus driven only in TA2+DATA, released after D0.
- Write reg4=16'h05E1 then read reg4 -> wr_valid once with addr=4, data=16'h05E1; readback 16'h05E1.
- Read reg1 with link_i=1, then link_i=0 -> bit2=1 then 0. Read reg17 with speed_i=10 -> 16'hA000.
- Write to PHYAD=3 (mismatch) and write to reg1 -> mdio_oe stays 0, no wr_valid, regfile unchanged.
- Write reg0=16'h9140 -> soft_rst pulse, subsequent read reg0 = 16'h1140.
- Stop MDC after REGAD of a read for 1100 clk -> FSM back in IDLE, mdio_oe=0. A following valid frame with full preamble is answered correctly. With MDIO_PREAMBLE_SUPPRESS_EN, a 1-bit-preamble frame is also answered.
